ttc_timer_counter_lite25: RTL and testbench

//  One 16-bit timer/counter channel of the triple timer counter (TTC).

---
 rtl/ttc_timer_counter_lite25.sv | 154 +++++++++++++++
 tb/tb_ttc_timer_counter_lite25.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttc_timer_counter_lite25.sv
// ttc_timer_counter_lite25: one 16-bit TTC channel (up/down, free-run/interval, 3 matches, restart).
// Optional prescaler is built when TTC_PRESCALER25_EN is defined.  Revision 1.0
`default_nettype none

module ttc_timer_counter_lite25 #(
  parameter int               CNT_W   = 16,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             pclk25,
  input  logic             p_reset25,
  input  logic [CNT_W-1:0] pwdata25,
  input  logic             cntr_ctrl_reg_sel25,
  input  logic             interval_reg_sel25,
  input  logic [2:0]       match_reg_sel25,
  input  logic             clk_ctrl_reg_sel25,
  output logic [CNT_W-1:0] count_val_out25,
  output logic [4:0]       cntr_ctrl_out25,
  output logic             interval_intr25,
  output logic [2:0]       match_intr25,
  output logic             overflow_intr25,
  output logic             restart25
);

  logic [3:0]       ctrl_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] interval_q;
  logic [CNT_W-1:0] match_q [3];
  logic [2:0]       match_wr_q;
  logic             restart_pend_q;
  logic             interval_intr_q, overflow_intr_q, restart_q;
  logic [2:0]       match_intr_q;
  logic             tick_d;
  logic             intv_evt_d, ovf_evt_d;
  logic [2:0]       match_evt_d;
  logic [CNT_W-1:0] intv_src_d;

  // A restart coinciding with an interval write reloads the freshly written value.
  assign intv_src_d = interval_reg_sel25 ? pwdata25 : interval_q;

`ifdef TTC_PRESCALER25_EN
  logic [3:0] clk_ctrl_q;
  logic [7:0] presc_q;
  logic [7:0] presc_max_d;

  assign presc_max_d = 8'((9'd2 << clk_ctrl_q[3:1]) - 9'd1);
  assign tick_d      = !clk_ctrl_q[0] || (presc_q == presc_max_d);

  always_ff @(posedge pclk25 or posedge p_reset25) begin
    if (p_reset25) begin
      clk_ctrl_q <= '0;
      presc_q    <= '0;
    end else begin
      if (clk_ctrl_reg_sel25) begin
        clk_ctrl_q <= pwdata25[3:0];
      end
      if (clk_ctrl_reg_sel25 || restart_pend_q || !clk_ctrl_q[0] || (presc_q == presc_max_d)) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + 8'd1;
      end
    end
  end
`else
  logic unused_clk_ctrl_sel;
  assign unused_clk_ctrl_sel = clk_ctrl_reg_sel25;
  assign tick_d              = 1'b1;
`endif

  always_comb begin
    count_d     = count_q;
    intv_evt_d  = 1'b0;
    ovf_evt_d   = 1'b0;
    match_evt_d = 3'b000;
    if (restart_pend_q) begin
      count_d = (ctrl_q[2] && ctrl_q[1]) ? intv_src_d : RST_VAL;
    end else if (!ctrl_q[0] && tick_d) begin
      if (!ctrl_q[2]) begin
        if (ctrl_q[1]) begin
          // ">=" also catches an interval lowered below the running count.
          if (count_q >= interval_q) begin
            count_d    = '0;
            intv_evt_d = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end else begin
          count_d   = count_q + 1'b1;
          ovf_evt_d = &count_q;
        end
      end else begin
        if (count_q == '0) begin
          if (ctrl_q[1]) begin
            count_d    = interval_q;
            intv_evt_d = 1'b1;
          end else begin
            count_d   = '1;
            ovf_evt_d = 1'b1;
          end
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      for (int n = 0; n < 3; n++) begin
        match_evt_d[n] = match_wr_q[n] && (count_d == match_q[n]);
      end
    end
  end

  always_ff @(posedge pclk25 or posedge p_reset25) begin
    if (p_reset25) begin
      count_q         <= RST_VAL;
      ctrl_q          <= '0;
      interval_q      <= '0;
      for (int n = 0; n < 3; n++) begin
        match_q[n] <= '1;
      end
      match_wr_q      <= '0;
      restart_pend_q  <= 1'b0;
      interval_intr_q <= 1'b0;
      overflow_intr_q <= 1'b0;
      restart_q       <= 1'b0;
      match_intr_q    <= '0;
    end else begin
      count_q         <= count_d;
      interval_intr_q <= intv_evt_d;
      overflow_intr_q <= ovf_evt_d;
      match_intr_q    <= match_evt_d;
      restart_q       <= restart_pend_q;
      restart_pend_q  <= cntr_ctrl_reg_sel25 && pwdata25[4];
      if (cntr_ctrl_reg_sel25) begin
        ctrl_q <= pwdata25[3:0];
      end
      if (interval_reg_sel25) begin
        interval_q <= pwdata25;
      end
      for (int n = 0; n < 3; n++) begin
        if (match_reg_sel25[n]) begin
          match_q[n]    <= pwdata25;
          match_wr_q[n] <= 1'b1;
        end
      end
    end
  end

  assign count_val_out25 = count_q;
  assign cntr_ctrl_out25 = {1'b0, ctrl_q};
  assign interval_intr25 = interval_intr_q;
  assign match_intr25    = match_intr_q;
  assign overflow_intr25 = overflow_intr_q;
  assign restart25       = restart_q;

endmodule

`default_nettype wire

// File: tb/tb_ttc_timer_counter_lite25.sv
// Bench for ttc_timer_counter_lite25: directed scenarios plus random register traffic against a cycle model.
`default_nettype none

module tb_ttc_timer_counter_lite25;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pwdata;
  logic        csel, isel, ksel;
  logic [2:0]  msel;

  logic [15:0] o0_cnt, o1_cnt;
  logic [4:0]  o0_ctrl, o1_ctrl;
  logic        o0_int, o1_int, o0_ovf, o1_ovf, o0_rst, o1_rst;
  logic [2:0]  o0_m, o1_m;

  int n_pass = 0;
  int n_tot  = 0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  ttc_timer_counter_lite25 dut0 (
    .pclk25(clk), .p_reset25(rst), .pwdata25(pwdata),
    .cntr_ctrl_reg_sel25(csel), .interval_reg_sel25(isel),
    .match_reg_sel25(msel), .clk_ctrl_reg_sel25(ksel),
    .count_val_out25(o0_cnt), .cntr_ctrl_out25(o0_ctrl),
    .interval_intr25(o0_int), .match_intr25(o0_m),
    .overflow_intr25(o0_ovf), .restart25(o0_rst)
  );

  ttc_timer_counter_lite25 #(.CNT_W(16), .RST_VAL(16'hFFFE)) dut1 (
    .pclk25(clk), .p_reset25(rst), .pwdata25(pwdata),
    .cntr_ctrl_reg_sel25(csel), .interval_reg_sel25(isel),
    .match_reg_sel25(msel), .clk_ctrl_reg_sel25(ksel),
    .count_val_out25(o1_cnt), .cntr_ctrl_out25(o1_ctrl),
    .interval_intr25(o1_int), .match_intr25(o1_m),
    .overflow_intr25(o1_ovf), .restart25(o1_rst)
  );

  // Reference model: register file shared by both channels, per-channel count/outputs.
  logic [3:0]  m_ctrl, m_clk;
  logic [15:0] m_intv;
  logic [15:0] m_match [3];
  logic        m_mwr   [3];
  logic        m_rpend;
  int          m_presc;
  logic [15:0] e_cnt [2];
  logic        e_int [2];
  logic        e_ovf [2];
  logic        e_rst [2];
  logic [2:0]  e_m   [2];

  function automatic logic [15:0] rst_val(input int i);
    return (i == 0) ? 16'h0000 : 16'hFFFE;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_ctrl = 0; m_clk = 0; m_intv = 0; m_rpend = 0; m_presc = 0;
    for (int n = 0; n < 3; n++) begin m_match[n] = 16'hFFFF; m_mwr[n] = 0; end
    for (int i = 0; i < 2; i++) begin
      e_cnt[i] = rst_val(i); e_int[i] = 0; e_ovf[i] = 0; e_rst[i] = 0; e_m[i] = 0;
    end
  endtask

  task automatic model_step();
    logic        tick;
    logic [15:0] isrc;
    int          nxt, period;
    isrc = isel ? pwdata : m_intv;
`ifdef TTC_PRESCALER25_EN
    period = 2 << m_clk[3:1];
    tick   = !m_clk[0] || ((m_presc % period) == period - 1);
`else
    period = 1;
    tick   = 1'b1;
`endif
    for (int i = 0; i < 2; i++) begin
      e_int[i] = 0; e_ovf[i] = 0; e_rst[i] = 0; e_m[i] = 0;
      if (m_rpend) begin
        e_rst[i] = 1;
        e_cnt[i] = (m_ctrl[2] && m_ctrl[1]) ? isrc : rst_val(i);
      end else if (!m_ctrl[0] && tick) begin
        nxt = int'(e_cnt[i]);
        if (!m_ctrl[2]) begin
          if (m_ctrl[1] && nxt >= int'(m_intv)) begin nxt = 0; e_int[i] = 1; end
          else begin
            nxt = nxt + 1;
            if (nxt == 65536) begin nxt = 0; e_ovf[i] = 1; end
          end
        end else begin
          if (nxt == 0 && m_ctrl[1]) begin nxt = int'(m_intv); e_int[i] = 1; end
          else if (nxt == 0) begin nxt = 65535; e_ovf[i] = 1; end
          else nxt = nxt - 1;
        end
        e_cnt[i] = nxt[15:0];
        for (int n = 0; n < 3; n++)
          if (m_mwr[n] && m_match[n] == e_cnt[i]) e_m[i][n] = 1;
      end
    end
`ifdef TTC_PRESCALER25_EN
    if (ksel || m_rpend || !m_clk[0]) m_presc = 0;
    else m_presc = m_presc + 1;
    if (ksel) m_clk = pwdata[3:0];
`endif
    m_rpend = csel && pwdata[4];
    if (csel) m_ctrl = pwdata[3:0];
    if (isel) m_intv = pwdata;
    for (int n = 0; n < 3; n++)
      if (msel[n]) begin m_match[n] = pwdata; m_mwr[n] = 1; end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cnt0", o0_cnt, e_cnt[0]);  chk("cnt1", o1_cnt, e_cnt[1]);
      chk("intv0", o0_int, e_int[0]); chk("intv1", o1_int, e_int[1]);
      chk("ovf0", o0_ovf, e_ovf[0]);  chk("ovf1", o1_ovf, e_ovf[1]);
      chk("rst0", o0_rst, e_rst[0]);  chk("rst1", o1_rst, e_rst[1]);
      chk("match0", o0_m, e_m[0]);    chk("match1", o1_m, e_m[1]);
      chk("ctrl0", o0_ctrl, {1'b0, m_ctrl});
      chk("ctrl1", o1_ctrl, {1'b0, m_ctrl});
    end
  end

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    csel = 0; isel = 0; ksel = 0; msel = 0;
  endtask

  task automatic wr_ctrl(input logic [15:0] v);  pwdata = v; csel = 1; cycle(); endtask
  task automatic wr_intv(input logic [15:0] v);  pwdata = v; isel = 1; cycle(); endtask
  task automatic wr_clk(input logic [15:0] v);   pwdata = v; ksel = 1; cycle(); endtask
  task automatic wr_match(input int n, input logic [15:0] v);
    pwdata = v; msel = 3'(1 << n); cycle();
  endtask

  initial begin
    int exp_c;
    rst = 1; pwdata = 0; csel = 0; isel = 0; ksel = 0; msel = 0;
    model_reset();
    cmp_en = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("T1 reset cnt0", o0_cnt, 16'h0000);
    chk("T1 reset cnt1", o1_cnt, 16'hFFFE);
    chk("T1 reset ctrl", o0_ctrl, 5'h00);

    // T1: free-running up count, then asynchronous reset mid-run
    repeat (16) cycle();
    @(negedge clk);
    chk("T1 cnt16", o0_cnt, 16'd16);
    chk("T1 no ovf", o0_ovf, 1'b0);
    #2 rst = 1;
    model_reset();
    #1;
    chk("T1 async cnt0", o0_cnt, 16'h0000);
    chk("T1 async cnt1", o1_cnt, 16'hFFFE);
    @(posedge clk);
    #1 rst = 0;

    // T2: restart preloads FFFE on the RST_VAL=FFFE channel, then wraps
    wr_ctrl(16'h0010);
    cycle();
    @(negedge clk);
    chk("T2 FFFE", o1_cnt, 16'hFFFE);
    chk("T2 restart", o1_rst, 1'b1);
    cycle(); @(negedge clk);
    chk("T2 FFFF", o1_cnt, 16'hFFFF);
    chk("T2 ovf early", o1_ovf, 1'b0);
    chk("T2 restart 1cyc", o1_rst, 1'b0);
    cycle(); @(negedge clk);
    chk("T2 0000", o1_cnt, 16'h0000);
    chk("T2 ovf", o1_ovf, 1'b1);
    cycle(); @(negedge clk);
    chk("T2 0001", o1_cnt, 16'h0001);
    chk("T2 ovf 1cyc", o1_ovf, 1'b0);

    // T3: up interval, interval=5
    wr_intv(16'd5);
    wr_ctrl(16'h0012);
    cycle(); @(negedge clk);
    chk("T3 start", o0_cnt, 16'd0);
    for (int k = 1; k <= 12; k++) begin
      cycle(); @(negedge clk);
      chk("T3 cnt", o0_cnt, 32'(k % 6));
      chk("T3 intv", o0_int, 32'(k % 6 == 0));
      chk("T3 no ovf", o0_ovf, 1'b0);
    end

    // T4: down interval, interval=3, match1=2
    wr_match(0, 16'd2);
    wr_intv(16'd3);
    wr_ctrl(16'h0016);
    cycle(); @(negedge clk);
    chk("T4 reload", o0_cnt, 16'd3);
    chk("T4 restart", o0_rst, 1'b1);
    chk("T4 no intv on restart", o0_int, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      exp_c = 3 - (k % 4);
      cycle(); @(negedge clk);
      chk("T4 cnt", o0_cnt, 32'(exp_c));
      chk("T4 intv", o0_int, 32'(k % 4 == 0));
      chk("T4 match1", o0_m[0], 32'(exp_c == 2));
    end

    // T5: restart at count 9 with match3=0 must not raise match3
    wr_match(2, 16'd0);
    wr_ctrl(16'h0010);
    cycle();
    repeat (9) cycle();
    @(negedge clk);
    chk("T5 cnt9", o0_cnt, 16'd9);
    wr_ctrl(16'h0010);
    cycle(); @(negedge clk);
    chk("T5 cnt0", o0_cnt, 16'd0);
    chk("T5 restart", o0_rst, 1'b1);
    chk("T5 match3 quiet", o0_m[2], 1'b0);

    // T6: prescaler N=1 (when built), otherwise ignored
    wr_clk(16'h0003);
    wr_ctrl(16'h0010);
    cycle();
    for (int k = 1; k <= 8; k++) begin
      cycle(); @(negedge clk);
`ifdef TTC_PRESCALER25_EN
      chk("T6 presc cnt", o0_cnt, 32'(k / 4));
`else
      chk("T6 cnt", o0_cnt, 32'(k));
`endif
    end
    wr_clk(16'h0000);

    // Random register traffic
    for (int c = 0; c < 3000; c++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4) begin
        pwdata = {11'd0, ($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 7) == 0)};
        csel = 1;
        if ($urandom_range(0, 3) == 0) isel = 1;
      end else if (r < 7) begin
        pwdata = 16'($urandom_range(0, 20)); isel = 1;
      end else if (r < 10) begin
        pwdata = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 20));
        msel = 3'(1 << $urandom_range(0, 2));
      end else if (r < 11) begin
        pwdata = 16'({$urandom_range(0, 2), 1'($urandom)}); ksel = 1;
      end
      cycle();
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
